// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: drives the PC into instruction memory, tracks
// the single in-flight request, and buffers returned words in a small queue
// that decode drains over a valid/ready handshake. Issue is throttled by
// credit (queued entries plus the in-flight word) so a response always has
// a free slot waiting for it.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_out,
    input  logic [31:0] mem_instr,
    input  logic        mem_stop,
    output logic        dq_valid,
    output logic [31:0] dq_instr,
    output logic [31:0] dq_pc,
    input  logic        dq_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic [31:0] fetch_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C   = (CW + 1)'(DEPTH);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t          state_q;
    logic [31:0]     pc_q;
    logic            inflight_v_q;
    logic [31:0]     inflight_pc_q;
    logic [31:0]     q_pc_q    [DEPTH];
    logic [31:0]     q_instr_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic [31:0]     fetch_cnt_q;

    logic            run;
    logic            stop_resp;
    logic            push;
    logic            pop;
    logic            issue;
    logic            pc_in_range;
    logic [CW:0]     credit_used;

    // Decode this cycle's events from registered state and the memory response.
    always_comb begin
        run         = (state_q == S_RUN);
        pc_in_range = (pc_q < MEM_LIMIT);
        credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_v_q};
        stop_resp   = run && inflight_v_q && mem_stop;
        push        = run && inflight_v_q && !mem_stop;
        pop         = (count_q != '0) && dq_ready;
        issue       = run && !redirect_valid && !stop_resp
                      && (credit_used < DEPTH_C) && pc_in_range;
    end

    // Control state: PC, in-flight tracking, queue pointers, RUN/HALT FSM.
    // Redirect outranks everything except reset and discards same-cycle
    // push, pop and stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_RUN;
            pc_q          <= RESET_PC;
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            fetch_cnt_q   <= '0;
        end else if (redirect_valid) begin
            state_q      <= S_RUN;
            pc_q         <= redirect_pc & ~32'h3;
            inflight_v_q <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            inflight_v_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + 32'd4;
            end
            // A stop word rewinds the PC to the terminating address.
            if (stop_resp) begin
                state_q <= S_HALT;
                pc_q    <= inflight_pc_q;
            end else if (run && !pc_in_range && !inflight_v_q) begin
                state_q <= S_HALT;
            end
            if (push) begin
                wr_ptr_q    <= wr_ptr_q + PW'(1);
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Queue storage: written at the tail on every accepted response.
    always_ff @(posedge clk) begin
        if (push && !redirect_valid && !rst) begin
            q_pc_q[wr_ptr_q]    <= inflight_pc_q;
            q_instr_q[wr_ptr_q] <= mem_instr;
        end
    end

    assign pc_out    = pc_q;
    assign dq_valid  = (count_q != '0);
    assign dq_pc     = q_pc_q[rd_ptr_q];
    assign dq_instr  = q_instr_q[rd_ptr_q];
    assign halted    = (state_q == S_HALT) && (count_q == '0);
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run checked
// against an in-order program-sequence model (each popped PC must be the next
// sequential address since the last redirect, carrying that memory word).
module tb_instr_fetch_unit;

    localparam int MEMB = 1024;

    logic        clk;
    logic        rst;
    logic [31:0] pc_out;
    logic [31:0] mem_instr;
    logic        mem_stop;
    logic        dq_valid;
    logic [31:0] dq_instr;
    logic [31:0] dq_pc;
    logic        dq_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic [31:0] fetch_cnt;

    // Second instance with a 16-byte memory window for the range-limit check.
    logic        rst_s;
    logic [31:0] pc_out_s;
    logic [31:0] mem_instr_s;
    logic        mem_stop_s;
    logic        dq_valid_s;
    logic [31:0] dq_instr_s;
    logic [31:0] dq_pc_s;
    logic        dq_ready_s;
    logic        redirect_valid_s;
    logic [31:0] redirect_pc_s;
    logic        halted_s;
    logic [31:0] fetch_cnt_s;

    logic [31:0] mem [256];
    int n_cmp;
    int n_bad;

    instr_fetch_unit #(.RESET_PC(32'h0), .DEPTH(4), .MEM_BYTES(MEMB)) dut (
        .clk(clk), .rst(rst), .pc_out(pc_out), .mem_instr(mem_instr),
        .mem_stop(mem_stop), .dq_valid(dq_valid), .dq_instr(dq_instr),
        .dq_pc(dq_pc), .dq_ready(dq_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halted(halted), .fetch_cnt(fetch_cnt)
    );

    instr_fetch_unit #(.RESET_PC(32'h0), .DEPTH(4), .MEM_BYTES(16)) dut_small (
        .clk(clk), .rst(rst_s), .pc_out(pc_out_s), .mem_instr(mem_instr_s),
        .mem_stop(mem_stop_s), .dq_valid(dq_valid_s), .dq_instr(dq_instr_s),
        .dq_pc(dq_pc_s), .dq_ready(dq_ready_s), .redirect_valid(redirect_valid_s),
        .redirect_pc(redirect_pc_s), .halted(halted_s), .fetch_cnt(fetch_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (a < 32'(MEMB)) return mem[8'(a >> 2)];
        return 32'hDEAD_BEEF;
    endfunction

    // Instruction memory: one-cycle registered read, zero word flags stop.
    always @(posedge clk) begin
        mem_instr   <= rd_word(pc_out);
        mem_stop    <= (rd_word(pc_out) == 32'h0);
        mem_instr_s <= rd_word(pc_out_s);
        mem_stop_s  <= (rd_word(pc_out_s) == 32'h0);
    end

    // Where a straight-line run starting at s must stop fetching.
    function automatic logic [31:0] halt_point(input logic [31:0] s);
        logic [31:0] p;
        p = s;
        for (int k = 0; k < 300; k++) begin
            if (p >= 32'(MEMB) || mem[8'(p >> 2)] == 32'h0) return p;
            p = p + 32'd4;
        end
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic fill_nonzero();
        for (int w = 0; w < 256; w++) mem[w] = $urandom() | 32'h1;
    endtask

    // Pop with dq_ready=1 until halted; every pop must be the next sequential PC.
    task automatic drain(input logic [31:0] start, input string tag);
        logic [31:0] e;
        logic done;
        e = start;
        done = 1'b0;
        dq_ready = 1'b1;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (halted) begin
                done = 1'b1;
                break;
            end
            if (dq_valid) begin
                n_cmp++;
                if (dq_pc !== e || dq_instr !== rd_word(e) || e >= 32'(MEMB) || rd_word(e) == 32'h0) begin
                    n_bad++;
                    $display("FAIL %s_pop: got pc=%h instr=%h want pc=%h instr=%h", tag, dq_pc, dq_instr, e, rd_word(e));
                end
                e = e + 32'd4;
            end
            tick();
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s_timeout: halted=%b want 1", tag, halted);
        end
        n_cmp++;
        if (e !== halt_point(start) || pc_out !== halt_point(start)) begin
            n_bad++;
            $display("FAIL %s_end: next_pc=%h pc_out=%h want %h", tag, e, pc_out, halt_point(start));
        end
        tick();
        $display("%s drained up to pc %h", tag, e);
    endtask

    task automatic test_reset();
        fill_nonzero();
        do_reset();
        dq_ready = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        rst = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        tick();
        rst = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (pc_out !== 32'h0 || dq_valid !== 1'b0 || halted !== 1'b0 || fetch_cnt !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: pc=%h valid=%b halted=%b cnt=%0d want 0/0/0/0", pc_out, dq_valid, halted, fetch_cnt);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (dq_valid !== 1'b0 || fetch_cnt !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_stale_resp: valid=%b cnt=%0d want 0/0", dq_valid, fetch_cnt);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (dq_valid !== 1'b1 || dq_pc !== 32'h0 || dq_instr !== mem[0]) begin
            n_bad++;
            $display("FAIL reset_first: valid=%b pc=%h instr=%h want 1/0/%h", dq_valid, dq_pc, dq_instr, mem[0]);
        end
        tick();
        $display("test_reset done");
    endtask

    task automatic test_stop_program();
        for (int w = 0; w < 4; w++) mem[w] = $urandom() | 32'h1;
        mem[4] = 32'h0;
        do_reset();
        dq_ready = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 5) begin
                n_cmp++;
                if (dq_valid !== 1'b1 || dq_pc !== 32'(4 * (c - 2)) || dq_instr !== mem[c - 2]) begin
                    n_bad++;
                    $display("FAIL stop_seq c%0d: valid=%b pc=%h instr=%h want 1/%h/%h", c, dq_valid, dq_pc, dq_instr, 32'(4 * (c - 2)), mem[c - 2]);
                end
            end
            if (c == 5) begin
                n_cmp++;
                if (halted !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stop_early_halt: halted=%b want 0", halted);
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (halted !== 1'b1 || pc_out !== 32'h10 || fetch_cnt !== 32'd4 || dq_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stop_final: halted=%b pc=%h cnt=%0d valid=%b want 1/10/4/0", halted, pc_out, fetch_cnt, dq_valid);
                end
            end
            tick();
        end
        $display("test_stop_program done");
    endtask

    task automatic test_backpressure();
        fill_nonzero();
        mem[64] = 32'h0;
        do_reset();
        dq_ready = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        @(negedge clk);
        n_cmp++;
        if (dq_valid !== 1'b1 || dq_pc !== 32'h0 || pc_out !== 32'h10 || fetch_cnt !== 32'd4) begin
            n_bad++;
            $display("FAIL bp_full: valid=%b pc=%h pc_out=%h cnt=%0d want 1/0/10/4", dq_valid, dq_pc, pc_out, fetch_cnt);
        end
        tick();
        drain(32'h0, "bp");
    endtask

    task automatic test_redirect();
        do_reset();
        dq_ready = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h43;
        dq_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dq_valid !== 1'b0 || pc_out !== 32'h40 || fetch_cnt !== 32'd3) begin
            n_bad++;
            $display("FAIL redir_next: valid=%b pc=%h cnt=%0d want 0/40/3", dq_valid, pc_out, fetch_cnt);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (dq_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL redir_gap: valid=%b want 0", dq_valid);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (dq_valid !== 1'b1 || dq_pc !== 32'h40 || dq_instr !== mem[16]) begin
            n_bad++;
            $display("FAIL redir_first: valid=%b pc=%h instr=%h want 1/40/%h", dq_valid, dq_pc, dq_instr, mem[16]);
        end
        tick();
        drain(32'h44, "redir");
    endtask

    task automatic test_halt_redirect();
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (halted !== 1'b0 || pc_out !== 32'h80) begin
            n_bad++;
            $display("FAIL hredir_next: halted=%b pc=%h want 0/80", halted, pc_out);
        end
        tick();
        tick();
        @(negedge clk);
        n_cmp++;
        if (dq_valid !== 1'b1 || dq_pc !== 32'h80) begin
            n_bad++;
            $display("FAIL hredir_first: valid=%b pc=%h want 1/80", dq_valid, dq_pc);
        end
        tick();
        drain(32'h84, "hredir");
    endtask

    task automatic test_out_of_range();
        logic [31:0] e;
        logic done;
        for (int w = 0; w < 8; w++) mem[w] = $urandom() | 32'h1;
        e = 32'h0;
        done = 1'b0;
        dq_ready_s = 1'b1;
        rst_s = 1'b1;
        tick();
        tick();
        rst_s = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n_cmp++;
            if (pc_out_s > 32'h10) begin
                n_bad++;
                $display("FAIL oor_pc_bound: pc=%h want <= 10", pc_out_s);
            end
            if (dq_valid_s) begin
                n_cmp++;
                if (dq_pc_s !== e || dq_instr_s !== mem[8'(e >> 2)] || e >= 32'h10) begin
                    n_bad++;
                    $display("FAIL oor_pop: pc=%h instr=%h want %h/%h", dq_pc_s, dq_instr_s, e, mem[8'(e >> 2)]);
                end
                e = e + 32'd4;
            end
            if (halted_s) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++;
        if (!done || e !== 32'h10 || pc_out_s !== 32'h10 || fetch_cnt_s !== 32'd4) begin
            n_bad++;
            $display("FAIL oor_final: halted=%b next=%h pc=%h cnt=%0d want 1/10/10/4", done, e, pc_out_s, fetch_cnt_s);
        end
        tick();
        rst_s = 1'b1;
        $display("test_out_of_range done");
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic        prev_stall;
        logic [31:0] prev_pc;
        logic [31:0] prev_instr;
        for (int w = 0; w < 256; w++)
            mem[w] = ($urandom_range(0, 19) == 0) ? 32'h0 : ($urandom() | 32'h1);
        do_reset();
        exp_pc = 32'h0;
        prev_stall = 1'b0;
        prev_pc = 32'h0;
        prev_instr = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            dq_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 29) == 0);
            tgt = 32'($urandom_range(0, 1100));
            redirect_pc = tgt;
            @(negedge clk);
            if (prev_stall) begin
                n_cmp++;
                if (dq_valid !== 1'b1 || dq_pc !== prev_pc || dq_instr !== prev_instr) begin
                    n_bad++;
                    $display("FAIL rnd_hold c%0d: valid=%b pc=%h instr=%h want 1/%h/%h", c, dq_valid, dq_pc, dq_instr, prev_pc, prev_instr);
                end
            end
            if (redirect_valid) begin
                exp_pc = tgt & ~32'h3;
                prev_stall = 1'b0;
            end else begin
                if (dq_valid && dq_ready) begin
                    n_cmp++;
                    if (dq_pc !== exp_pc || dq_instr !== rd_word(exp_pc) || exp_pc >= 32'(MEMB) || rd_word(exp_pc) == 32'h0) begin
                        n_bad++;
                        $display("FAIL rnd_pop c%0d: pc=%h instr=%h want %h/%h", c, dq_pc, dq_instr, exp_pc, rd_word(exp_pc));
                    end
                    exp_pc = exp_pc + 32'd4;
                end
                prev_stall = dq_valid && !dq_ready;
                prev_pc = dq_pc;
                prev_instr = dq_instr;
            end
            tick();
        end
        redirect_valid = 1'b0;
        drain(exp_pc, "rnd");
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        rst_s = 1'b1;
        dq_ready = 1'b0;
        dq_ready_s = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        redirect_valid_s = 1'b0;
        redirect_pc_s = 32'h0;
        for (int w = 0; w < 256; w++) mem[w] = 32'h1;
        tick();
        test_reset();
        test_stop_program();
        test_backpressure();
        test_redirect();
        test_halt_redirect();
        test_out_of_range();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
